// File: rtl/data_bus_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_responder_pkg
// Description : Shared constants for the data-side bus responder: the MMIO
//               window base, the register word offsets and the STATUS bit map.
// Revision    : 1.0 - initial release
// ============================================================================
package data_bus_responder_pkg;

    localparam logic [31:0] c_mmio_base_default = 32'hFFFF_0000;

    // Register selects are word offsets within the window, taken from aluout[3:2]
    localparam logic [1:0] c_reg_timer   = 2'd0;
    localparam logic [1:0] c_reg_compare = 2'd1;
    localparam logic [1:0] c_reg_status  = 2'd2;
    localparam logic [1:0] c_reg_txdata  = 2'd3;

    localparam int c_st_irq      = 0;
    localparam int c_st_full     = 1;
    localparam int c_st_empty    = 2;
    localparam int c_st_overflow = 3;
    localparam int c_st_count    = 4;

endpackage
`default_nettype wire

// File: rtl/data_bus_responder_console_fifo.sv
`default_nettype none
// ============================================================================
// Module      : console_fifo
// Description : Synchronous FIFO for the console stream; a push into a full
//               FIFO is accepted when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module console_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [3:0]       count,
    output logic             dropped
);
    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [3:0]         r_count;
    logic               w_pop;
    logic               w_push;

    assign empty   = (r_count == 4'd0);
    assign full    = (r_count == 4'(DEPTH));
    assign count   = r_count;
    assign w_pop   = pop && !empty;
    assign w_push  = push && (!full || w_pop);
    assign dropped = push && !w_push;
    // Gating on empty keeps the head at zero after reset discards the contents
    assign dout    = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 4'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 4'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_responder
// Description : Data-bus responder for the single-cycle MIPS core: word RAM,
//               timer/compare interrupt and console transmit FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module data_bus_responder
    import data_bus_responder_pkg::*;
#(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = c_mmio_base_default
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        console_valid,
    output logic [7:0]  console_data,
    input  logic        console_ready,
    output logic        irq_timer
);
    localparam int c_ram_aw = $clog2(RAM_WORDS);

    logic [31:0]         r_ram [RAM_WORDS];
    logic [31:0]         r_timer;
    logic [31:0]         r_compare;
    logic                r_irq;
    logic                r_overflow;

    logic                w_ram_sel;
    logic                w_mmio_sel;
    logic [c_ram_aw-1:0] w_ram_idx;
    logic [1:0]          w_reg;
    logic                w_wr_timer;
    logic                w_wr_compare;
    logic                w_wr_status;
    logic                w_wr_txdata;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_dropped;
    logic [3:0]          w_count;
    logic [31:0]         w_status;

    assign w_ram_sel    = (aluout < 32'(RAM_WORDS * 4));
    assign w_mmio_sel   = (aluout[31:4] == MMIO_BASE[31:4]);
    assign w_ram_idx    = aluout[c_ram_aw+1:2];
    assign w_reg        = aluout[3:2];
    assign w_wr_timer   = memwrite && w_mmio_sel && (w_reg == c_reg_timer);
    assign w_wr_compare = memwrite && w_mmio_sel && (w_reg == c_reg_compare);
    assign w_wr_status  = memwrite && w_mmio_sel && (w_reg == c_reg_status);
    assign w_wr_txdata  = memwrite && w_mmio_sel && (w_reg == c_reg_txdata);
    assign w_pop        = console_valid && console_ready;
    assign console_valid = !w_empty;
    assign irq_timer     = r_irq;

    console_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_console_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (w_wr_txdata),
        .pop     (w_pop),
        .din     (writedata[7:0]),
        .dout    (console_data),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count),
        .dropped (w_dropped)
    );

    always_comb begin
        w_status                      = '0;
        w_status[c_st_irq]            = r_irq;
        w_status[c_st_full]           = w_full;
        w_status[c_st_empty]          = w_empty;
        w_status[c_st_overflow]       = r_overflow;
        w_status[c_st_count +: 4]     = w_count;
    end

    always_comb begin
        readdata = '0;
        if (w_ram_sel) begin
            readdata = r_ram[w_ram_idx];
        end else if (w_mmio_sel) begin
            case (w_reg)
                c_reg_timer:   readdata = r_timer;
                c_reg_compare: readdata = r_compare;
                c_reg_status:  readdata = w_status;
                default:       readdata = '0;
            endcase
        end
    end

    // RAM contents survive reset
    always_ff @(posedge clk) begin
        if (memwrite && w_ram_sel) begin
            r_ram[w_ram_idx] <= writedata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer    <= 32'd0;
            r_compare  <= 32'hFFFF_FFFF;
            r_irq      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_timer <= w_wr_timer ? writedata : r_timer + 32'd1;
            if (w_wr_compare) begin
                r_compare <= writedata;
            end
            // Sets take priority over a coinciding write-1-to-clear
            r_irq      <= (r_timer == r_compare) ||
                          (r_irq && !(w_wr_status && writedata[c_st_irq]));
            r_overflow <= w_dropped ||
                          (r_overflow && !(w_wr_status && writedata[c_st_overflow]));
        end
    end

endmodule
`default_nettype wire

// File: doc/data_bus_responder.md
# data_bus_responder

Data-side memory responder for the single-cycle MIPS core. Sits on the core's data bus (`memwrite`, `aluout`, `writedata`, `readdata`) and serves three regions: a word RAM, a free-running timer with a compare interrupt, and a console transmit FIFO drained over a valid/ready stream. Reads are combinational so the core sees data in the same cycle; all state changes happen on the rising clock edge.

## Interface
- `RAM_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `FIFO_DEPTH`, 8: console FIFO depth; power of two, at most 15.
- `MMIO_BASE`, 32'hFFFF_0000: base of the peripheral register window.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `memwrite`  in  1: write strobe from the core, sampled at the clock edge.
- `aluout`  in  32: byte address from the core; bits [1:0] are ignored.
- `writedata`  in  32: store data.
- `readdata`  out  32: combinational load data for `aluout`.
- `console_valid`  out  1: FIFO non-empty.
- `console_data`  out  8: FIFO head byte.
- `console_ready`  in  1: sink accepts the head byte.
- `irq_timer`  out  1: timer interrupt pending (level).

## Operation
- Decode on the word address.
  - RAM: `aluout < RAM_WORDS*4`, index `aluout[log2(RAM_WORDS)+1:2]`.
  - MMIO: `aluout[31:4] == MMIO_BASE[31:4]`.
  - Anything else is unmapped: reads return 0, writes are ignored.
- MMIO offsets:
  - 0x0 TIMER: read/write.
  - 0x4 COMPARE: read/write.
  - 0x8 STATUS: read, with write-1-to-clear bits.
  - 0xC TXDATA: write-only; reads return 0.
- STATUS layout:
  - bit0 irq pending.
  - bit1 FIFO full.
  - bit2 FIFO empty.
  - bit3 overflow (sticky).
  - bits[7:4] FIFO count.
  - All other bits read 0.
- TIMER: 32-bit counter, increments every cycle and wraps 0xFFFF_FFFF→0. A write loads `writedata`, and there is no increment that cycle.
- Match: when the TIMER register value equals COMPARE, bit0 sets on the next edge.
  - Bit0 stays set until a STATUS write with `writedata[0]=1`.
  - If a set and a clear coincide, set wins.
  - `irq_timer` equals bit0.
- TXDATA write pushes `writedata[7:0]`.
  - The push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow (bit3) sets.
  - A STATUS write with `writedata[3]=1` clears overflow; a set in the same cycle wins.
- Pop occurs when `console_valid && console_ready`. A simultaneous push and pop leaves the count unchanged.
- RAM write: when `memwrite` is high and the address is in RAM, the whole word is written at the edge.

## Timing
- Read latency: 0 cycles, combinational from `aluout` and the current state. A read of an address written in the same cycle returns the old value.
- Write latency: 1 edge.
- Reset values:
  - TIMER = 0 and COMPARE = 0xFFFF_FFFF.
  - Irq and overflow cleared, so `irq_timer` = 0.
  - FIFO empty, so `console_valid` = 0 and `console_data` = 0.
  - `readdata` follows decode with the reset state.
  - RAM contents are not cleared.
- Reset mid-operation: FIFO contents are discarded immediately, and `console_valid` drops asynchronously.
- Handshake:
  - `console_data` is stable while `console_valid` is high and `console_ready` is low.
  - `console_valid` rises the cycle after a push into an empty FIFO; there is no fall-through.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Count width is 4 bits, and count reaches `FIFO_DEPTH` when full.

## Structure
- Shared package: `MMIO_BASE` default, register offsets (TIMER/COMPARE/STATUS/TXDATA), and STATUS bit positions.
- Sub-module `console_fifo`: parameterised synchronous FIFO with push/pop/full/empty/count, asynchronous reset. Top level holds decode, RAM, timer, and status.

## Test plan
- RAM: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 → 0xDEADBEEF. Read 0x0000_0013 → 0xDEADBEEF (low bits ignored). Read unmapped 0x0001_0000 → 0.
- Timer: after reset, read TIMER at cycle n → n−1 relative to the first post-reset edge. Write TIMER=0xFFFF_FFFE, then read after 2 cycles → 0x0000_0000 (wrap).
- Irq: write COMPARE=20 and TIMER=10. `irq_timer` rises the edge after TIMER reads 20. STATUS write 0x1 clears it. Clear coinciding with a match leaves it set.
- FIFO: with `console_ready`=0, push 0x41..0x48 → STATUS = 0x0000_0082 (count 8, full). A 9th push (0x49) is dropped and bit3 sets. Then raise ready → bytes 0x41..0x48 emerge in order, one per cycle.
- Push while full with ready=1 → accepted, count stays 8, no overflow.
- Assert `reset` asynchronously mid-drain with 3 bytes queued → `console_valid`=0, `irq_timer`=0, and STATUS reads 0x04 within the same cycle.
